// File: rtl/xintf_uart_sched.sv
// xintf_uart_sched: moves DSP-bus words to the byte UART and back.
// DSP writes are queued as 16-bit words and sent high byte first; UART RX bytes
// are paired into words, queued, and handed to the DSP on each read strobe.
module xintf_uart_sched #(
  parameter int unsigned TX_DEPTH   = 8,
  parameter int unsigned RX_DEPTH   = 8,
  parameter int unsigned RX_TIMEOUT = 50000,
  parameter logic [15:0] EMPTY_WORD = 16'h0000
) (
  input  logic        clk50M,
  input  logic        rst_n,
  input  logic [15:0] xwr_data,
  input  logic        wr_end,
  input  logic        rd_fall,
  input  logic        rd_end,
  output logic [15:0] xrd_data,
  output logic [7:0]  tx_data,
  output logic        tx_start,
  input  logic        tx_busy,
  input  logic [7:0]  rx_data,
  input  logic        rx_done,
  input  logic        err_clr,
  output logic        rx_avail,
  output logic        tx_full,
  output logic        tx_ovf,
  output logic        rx_ovf,
  output logic        rx_tmo
);

  localparam int unsigned TAW = $clog2(TX_DEPTH);
  localparam int unsigned RAW = $clog2(RX_DEPTH);
  localparam int unsigned TMW = $clog2(RX_TIMEOUT + 1);

  localparam logic [TAW-1:0] TX_PTR_ONE  = TAW'(1);
  localparam logic [TAW:0]   TX_CNT_ONE  = (TAW+1)'(1);
  localparam logic [TAW:0]   TX_CNT_ZERO = (TAW+1)'(0);
  localparam logic [TAW:0]   TX_FULL_CNT = (TAW+1)'(TX_DEPTH);
  localparam logic [RAW-1:0] RX_PTR_ONE  = RAW'(1);
  localparam logic [RAW:0]   RX_CNT_ONE  = (RAW+1)'(1);
  localparam logic [RAW:0]   RX_CNT_ZERO = (RAW+1)'(0);
  localparam logic [RAW:0]   RX_FULL_CNT = (RAW+1)'(RX_DEPTH);
  localparam logic [TMW-1:0] TMO_LOAD    = TMW'(RX_TIMEOUT);
  localparam logic [TMW-1:0] TMO_ONE     = TMW'(1);
  localparam logic [TMW-1:0] TMO_ZERO    = TMW'(0);

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_SEND_HI = 3'd1,
    ST_WAIT_HB = 3'd2,
    ST_WAIT_HI = 3'd3,
    ST_SEND_LO = 3'd4,
    ST_WAIT_LB = 3'd5,
    ST_WAIT_LI = 3'd6
  } tx_state_e;

  tx_state_e      state_q, state_d;
  logic [15:0]    tx_mem_q [TX_DEPTH];
  logic [TAW-1:0] tx_wptr_q, tx_wptr_d, tx_rptr_q, tx_rptr_d;
  logic [TAW:0]   tx_cnt_q, tx_cnt_d;
  logic [7:0]     tx_data_q, tx_data_d, tx_lo_q, tx_lo_d;
  logic           tx_start_q, tx_start_d;
  logic           tx_push_s, tx_pop_s, tx_drop_s, tx_full_s;
  logic [15:0]    tx_head_s;

  logic [15:0]    rx_mem_q [RX_DEPTH];
  logic [RAW-1:0] rx_wptr_q, rx_wptr_d, rx_rptr_q, rx_rptr_d;
  logic [RAW:0]   rx_cnt_q, rx_cnt_d;
  logic           rx_lo_phase_q, rx_lo_phase_d;
  logic [7:0]     rx_hi_q, rx_hi_d;
  logic [TMW-1:0] rx_timer_q, rx_timer_d;
  logic           rx_push_s, rx_pop_s, rx_drop_s, rx_tmo_s, rx_full_s;

  logic           rd_pend_q, rd_pend_d;
  logic [15:0]    xrd_data_q, xrd_data_d;
  logic           tx_ovf_q, tx_ovf_d, rx_ovf_q, rx_ovf_d, rx_tmo_q, rx_tmo_d;

  assign tx_full_s = (tx_cnt_q == TX_FULL_CNT);
  assign rx_full_s = (rx_cnt_q == RX_FULL_CNT);
  assign tx_head_s = tx_mem_q[tx_rptr_q];

  // TX sequencing: pop a word, send its high byte, then its low byte, each handshaked on tx_busy
  always_comb begin
    state_d    = state_q;
    tx_start_d = 1'b0;
    tx_data_d  = tx_data_q;
    tx_lo_d    = tx_lo_q;
    tx_pop_s   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if ((tx_cnt_q != TX_CNT_ZERO) && !tx_busy) state_d = ST_SEND_HI;
        else state_d = ST_IDLE;
      end
      ST_SEND_HI: begin
        tx_pop_s   = 1'b1;
        tx_start_d = 1'b1;
        tx_data_d  = tx_head_s[15:8];
        tx_lo_d    = tx_head_s[7:0];
        state_d    = ST_WAIT_HB;
      end
      ST_WAIT_HB: begin
        if (tx_busy) state_d = ST_WAIT_HI;
        else state_d = ST_WAIT_HB;
      end
      ST_WAIT_HI: begin
        if (!tx_busy) state_d = ST_SEND_LO;
        else state_d = ST_WAIT_HI;
      end
      ST_SEND_LO: begin
        tx_start_d = 1'b1;
        tx_data_d  = tx_lo_q;
        state_d    = ST_WAIT_LB;
      end
      ST_WAIT_LB: begin
        if (tx_busy) state_d = ST_WAIT_LI;
        else state_d = ST_WAIT_LB;
      end
      ST_WAIT_LI: begin
        if (!tx_busy) state_d = ST_IDLE;
        else state_d = ST_WAIT_LI;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // TX FIFO pointers and occupancy; a full FIFO drops the write before any same-cycle pop
  always_comb begin
    tx_push_s = wr_end & ~tx_full_s;
    tx_drop_s = wr_end & tx_full_s;
    tx_wptr_d = tx_push_s ? (tx_wptr_q + TX_PTR_ONE) : tx_wptr_q;
    tx_rptr_d = tx_pop_s ? (tx_rptr_q + TX_PTR_ONE) : tx_rptr_q;
    case ({tx_push_s, tx_pop_s})
      2'b10:   tx_cnt_d = tx_cnt_q + TX_CNT_ONE;
      2'b01:   tx_cnt_d = tx_cnt_q - TX_CNT_ONE;
      default: tx_cnt_d = tx_cnt_q;
    endcase
  end

  // RX byte pairing with inter-byte timeout; a pop in the same cycle frees room for a push
  always_comb begin
    rx_lo_phase_d = rx_lo_phase_q;
    rx_hi_d       = rx_hi_q;
    rx_timer_d    = rx_timer_q;
    rx_push_s     = 1'b0;
    rx_drop_s     = 1'b0;
    rx_tmo_s      = 1'b0;
    rx_pop_s      = rd_end & rd_pend_q;
    if (rx_done) begin
      if (!rx_lo_phase_q) begin
        rx_hi_d       = rx_data;
        rx_lo_phase_d = 1'b1;
        rx_timer_d    = TMO_LOAD;
      end else begin
        rx_lo_phase_d = 1'b0;
        rx_push_s     = ~rx_full_s | rx_pop_s;
        rx_drop_s     = rx_full_s & ~rx_pop_s;
      end
    end else if (rx_lo_phase_q) begin
      if (rx_timer_q == TMO_ZERO) begin
        rx_lo_phase_d = 1'b0;
        rx_tmo_s      = 1'b1;
      end else begin
        rx_timer_d = rx_timer_q - TMO_ONE;
      end
    end else begin
      rx_timer_d = rx_timer_q;
    end
    rx_wptr_d = rx_push_s ? (rx_wptr_q + RX_PTR_ONE) : rx_wptr_q;
    rx_rptr_d = rx_pop_s ? (rx_rptr_q + RX_PTR_ONE) : rx_rptr_q;
    case ({rx_push_s, rx_pop_s})
      2'b10:   rx_cnt_d = rx_cnt_q + RX_CNT_ONE;
      2'b01:   rx_cnt_d = rx_cnt_q - RX_CNT_ONE;
      default: rx_cnt_d = rx_cnt_q;
    endcase
  end

  // DSP read: capture head on read start, pop only at the end of a read that found data
  always_comb begin
    xrd_data_d = xrd_data_q;
    rd_pend_d  = rd_pend_q;
    if (rd_fall) begin
      if (rx_cnt_q != RX_CNT_ZERO) begin
        xrd_data_d = rx_mem_q[rx_rptr_q];
        rd_pend_d  = 1'b1;
      end else begin
        xrd_data_d = EMPTY_WORD;
        rd_pend_d  = 1'b0;
      end
    end else if (rd_end) begin
      rd_pend_d = 1'b0;
    end else begin
      rd_pend_d = rd_pend_q;
    end
  end

  // Sticky error flags: a new error in the clearing cycle keeps the flag set
  always_comb begin
    tx_ovf_d = (tx_ovf_q & ~err_clr) | tx_drop_s;
    rx_ovf_d = (rx_ovf_q & ~err_clr) | rx_drop_s;
    rx_tmo_d = (rx_tmo_q & ~err_clr) | rx_tmo_s;
  end

  // FIFO storage, written only on accepted pushes
  always_ff @(posedge clk50M) begin
    if (tx_push_s) tx_mem_q[tx_wptr_q] <= xwr_data;
    if (rx_push_s) rx_mem_q[rx_wptr_q] <= {rx_hi_q, rx_data};
  end

  // State registers with asynchronous reset
  always_ff @(posedge clk50M or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_IDLE;
      tx_wptr_q     <= '0;
      tx_rptr_q     <= '0;
      tx_cnt_q      <= '0;
      tx_data_q     <= 8'h00;
      tx_lo_q       <= 8'h00;
      tx_start_q    <= 1'b0;
      rx_wptr_q     <= '0;
      rx_rptr_q     <= '0;
      rx_cnt_q      <= '0;
      rx_lo_phase_q <= 1'b0;
      rx_hi_q       <= 8'h00;
      rx_timer_q    <= '0;
      rd_pend_q     <= 1'b0;
      xrd_data_q    <= EMPTY_WORD;
      tx_ovf_q      <= 1'b0;
      rx_ovf_q      <= 1'b0;
      rx_tmo_q      <= 1'b0;
    end else begin
      state_q       <= state_d;
      tx_wptr_q     <= tx_wptr_d;
      tx_rptr_q     <= tx_rptr_d;
      tx_cnt_q      <= tx_cnt_d;
      tx_data_q     <= tx_data_d;
      tx_lo_q       <= tx_lo_d;
      tx_start_q    <= tx_start_d;
      rx_wptr_q     <= rx_wptr_d;
      rx_rptr_q     <= rx_rptr_d;
      rx_cnt_q      <= rx_cnt_d;
      rx_lo_phase_q <= rx_lo_phase_d;
      rx_hi_q       <= rx_hi_d;
      rx_timer_q    <= rx_timer_d;
      rd_pend_q     <= rd_pend_d;
      xrd_data_q    <= xrd_data_d;
      tx_ovf_q      <= tx_ovf_d;
      rx_ovf_q      <= rx_ovf_d;
      rx_tmo_q      <= rx_tmo_d;
    end
  end

  assign xrd_data = xrd_data_q;
  assign tx_data  = tx_data_q;
  assign tx_start = tx_start_q;
  assign rx_avail = (rx_cnt_q != RX_CNT_ZERO);
  assign tx_full  = tx_full_s;
  assign tx_ovf   = tx_ovf_q;
  assign rx_ovf   = rx_ovf_q;
  assign rx_tmo   = rx_tmo_q;

endmodule

// File: tb/tb_xintf_uart_sched.sv
// Bench for xintf_uart_sched: directed stimulus, a queue-based reference model
// checked every cycle, and literal expectations for the documented scenarios.
module tb_xintf_uart_sched;
  localparam int TXD = 8;
  localparam int RXD = 8;
  localparam int TMO = 40;
  localparam logic [15:0] EMPTY = 16'hDEAD;

  logic        clk50M = 1'b0;
  logic        rst_n;
  logic [15:0] xwr_data;
  logic        wr_end, rd_fall, rd_end;
  logic [15:0] xrd_data;
  logic [7:0]  tx_data;
  logic        tx_start, tx_busy;
  logic [7:0]  rx_data;
  logic        rx_done, err_clr;
  logic        rx_avail, tx_full, tx_ovf, rx_ovf, rx_tmo;

  xintf_uart_sched #(
    .TX_DEPTH(TXD), .RX_DEPTH(RXD), .RX_TIMEOUT(TMO), .EMPTY_WORD(EMPTY)
  ) dut (
    .clk50M(clk50M), .rst_n(rst_n), .xwr_data(xwr_data), .wr_end(wr_end),
    .rd_fall(rd_fall), .rd_end(rd_end), .xrd_data(xrd_data), .tx_data(tx_data),
    .tx_start(tx_start), .tx_busy(tx_busy), .rx_data(rx_data), .rx_done(rx_done),
    .err_clr(err_clr), .rx_avail(rx_avail), .tx_full(tx_full), .tx_ovf(tx_ovf),
    .rx_ovf(rx_ovf), .rx_tmo(rx_tmo)
  );

  always #10 clk50M = ~clk50M;

  int n_checks = 0;
  int n_err = 0;

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // UART TX stand-in: busy for 10 cycles after each start, or held busy on request
  int   busy_cnt;
  logic busy_force = 1'b0;
  initial begin
    tx_busy  = 1'b0;
    busy_cnt = 0;
    forever begin
      @(negedge clk50M);
      if (tx_start) busy_cnt = 10;
      @(posedge clk50M);
      #1;
      if (busy_cnt > 0) begin
        tx_busy = 1'b1;
        busy_cnt--;
      end else begin
        tx_busy = busy_force;
      end
    end
  end

  // Reference model: byte stream queue for TX, word queue for RX, cycle stamps for timeout
  logic [7:0]  exp_bytes[$];
  logic [15:0] m_rxq[$];
  int          m_tx_acc, m_hi_started, m_byte_idx, m_cyc, m_t0;
  logic [7:0]  m_last_byte, m_hi, m_b;
  logic [15:0] m_xrd, m_w;
  logic        m_ph_lo, m_pend, m_txovf, m_rxovf, m_rxtmo;
  logic        n_tx, n_rx, n_tmo, m_pop, m_push;

  initial begin
    forever begin
      @(negedge clk50M or negedge rst_n);
      if (!rst_n) begin
        exp_bytes.delete();
        m_rxq.delete();
        m_tx_acc = 0; m_hi_started = 0; m_byte_idx = 0; m_cyc = 0; m_t0 = 0;
        m_last_byte = 8'h00; m_hi = 8'h00; m_xrd = EMPTY;
        m_ph_lo = 1'b0; m_pend = 1'b0; m_txovf = 1'b0; m_rxovf = 1'b0; m_rxtmo = 1'b0;
      end else begin
        // outputs produced by the last edge
        if (tx_start) begin
          if (exp_bytes.size() == 0) begin
            n_checks++;
            n_err++;
            $display("FAIL tx_extra_start: tx_data=%h but no byte pending at %0t", tx_data, $time);
          end else begin
            m_b = exp_bytes.pop_front();
            chk("tx_byte", 16'(tx_data), 16'(m_b));
            if (m_byte_idx % 2 == 0) m_hi_started++;
            m_byte_idx++;
            m_last_byte = m_b;
          end
        end else begin
          chk("tx_data_hold", 16'(tx_data), 16'(m_last_byte));
        end
        chk("tx_full", 16'(tx_full), 16'((m_tx_acc - m_hi_started) == TXD));
        chk("rx_avail", 16'(rx_avail), 16'(m_rxq.size() != 0));
        chk("xrd_data", xrd_data, m_xrd);
        chk("tx_ovf", 16'(tx_ovf), 16'(m_txovf));
        chk("rx_ovf", 16'(rx_ovf), 16'(m_rxovf));
        chk("rx_tmo", 16'(rx_tmo), 16'(m_rxtmo));
        // effect of the coming edge, from the inputs now applied
        m_cyc++;
        n_tx = 1'b0; n_rx = 1'b0; n_tmo = 1'b0; m_push = 1'b0;
        if (wr_end) begin
          if ((m_tx_acc - m_hi_started) < TXD) begin
            exp_bytes.push_back(xwr_data[15:8]);
            exp_bytes.push_back(xwr_data[7:0]);
            m_tx_acc++;
          end else begin
            n_tx = 1'b1;
          end
        end
        m_pop = rd_end && m_pend;
        if (rd_fall) begin
          if (m_rxq.size() > 0) begin
            m_xrd = m_rxq[0];
            m_pend = 1'b1;
          end else begin
            m_xrd = EMPTY;
            m_pend = 1'b0;
          end
        end else if (rd_end) begin
          m_pend = 1'b0;
        end
        if (rx_done) begin
          if (!m_ph_lo) begin
            m_hi = rx_data; m_ph_lo = 1'b1; m_t0 = m_cyc;
          end else begin
            m_ph_lo = 1'b0;
            m_w = {m_hi, rx_data};
            if (m_rxq.size() < RXD || m_pop) m_push = 1'b1;
            else n_rx = 1'b1;
          end
        end else if (m_ph_lo && (m_cyc - m_t0 > TMO)) begin
          m_ph_lo = 1'b0;
          n_tmo = 1'b1;
        end
        if (m_pop) void'(m_rxq.pop_front());
        if (m_push) m_rxq.push_back(m_w);
        m_txovf = (m_txovf && !err_clr) || n_tx;
        m_rxovf = (m_rxovf && !err_clr) || n_rx;
        m_rxtmo = (m_rxtmo && !err_clr) || n_tmo;
      end
    end
  end

  task automatic tick();
    @(posedge clk50M);
    #1;
  endtask

  task automatic pulse_wr(input logic [15:0] w);
    xwr_data = w; wr_end = 1'b1; tick(); wr_end = 1'b0;
  endtask

  task automatic pulse_rx(input logic [7:0] b);
    rx_data = b; rx_done = 1'b1; tick(); rx_done = 1'b0;
  endtask

  task automatic rx_word(input logic [15:0] w);
    pulse_rx(w[15:8]);
    pulse_rx(w[7:0]);
  endtask

  task automatic pulse_rdf();
    rd_fall = 1'b1; tick(); rd_fall = 1'b0;
  endtask

  task automatic pulse_rde();
    rd_end = 1'b1; tick(); rd_end = 1'b0;
  endtask

  task automatic pulse_clr();
    err_clr = 1'b1; tick(); err_clr = 1'b0;
  endtask

  logic [7:0] seen[$];

  task automatic collect(input int n, input int budget, output int got);
    got = 0;
    for (int i = 0; i < budget && got < n; i++) begin
      tick();
      if (tx_start) begin
        seen.push_back(tx_data);
        got++;
      end
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  int got;
  int found;

  initial begin
    rst_n = 1'b0; xwr_data = 16'h0000; wr_end = 1'b0; rd_fall = 1'b0; rd_end = 1'b0;
    rx_data = 8'h00; rx_done = 1'b0; err_clr = 1'b0;
    repeat (3) tick();
    chk("reset_xrd", xrd_data, EMPTY);
    chk("reset_tx_start", 16'(tx_start), 16'h0000);
    chk("reset_flags", 16'({rx_avail, tx_full, tx_ovf, rx_ovf, rx_tmo}), 16'h0000);
    rst_n = 1'b1;
    repeat (2) tick();

    // 1: one word out as two bytes
    seen.delete();
    pulse_wr(16'h5555);
    collect(2, 100, got);
    chk("t1_starts", 16'(got), 16'd2);
    chk("t1_byte0", 16'(seen[0]), 16'h0055);
    chk("t1_byte1", 16'(seen[1]), 16'h0055);
    repeat (20) tick();
    chk("t1_tx_full", 16'(tx_full), 16'h0000);

    // 2: two RX bytes form one word
    rx_word(16'hAAA1);
    chk("t2_avail", 16'(rx_avail), 16'h0001);
    pulse_rdf();
    chk("t2_xrd", xrd_data, 16'hAAA1);
    pulse_rde();
    chk("t2_avail_after", 16'(rx_avail), 16'h0000);

    // 3: TX overflow while the UART is held busy, then drain in order
    busy_force = 1'b1;
    repeat (2) tick();
    for (int i = 0; i < 9; i++) pulse_wr(16'h1000 | 16'(i));
    chk("t3_full", 16'(tx_full), 16'h0001);
    chk("t3_ovf", 16'(tx_ovf), 16'h0001);
    pulse_clr();
    chk("t3_ovf_clr", 16'(tx_ovf), 16'h0000);
    busy_force = 1'b0;
    seen.delete();
    collect(16, 800, got);
    chk("t3_starts", 16'(got), 16'd16);
    for (int k = 0; k < 8 && 2 * k + 1 < seen.size(); k++) begin
      chk("t3_hi", 16'(seen[2*k]), 16'h0010);
      chk("t3_lo", 16'(seen[2*k+1]), 16'(k));
    end
    repeat (30) tick();

    // 4: lone byte times out, following pair still forms a word
    pulse_rx(8'h12);
    repeat (TMO) tick();
    chk("t4_tmo_early", 16'(rx_tmo), 16'h0000);
    tick();
    chk("t4_tmo", 16'(rx_tmo), 16'h0001);
    chk("t4_nopush", 16'(rx_avail), 16'h0000);
    rx_word(16'h3456);
    pulse_rdf();
    chk("t4_xrd", xrd_data, 16'h3456);
    pulse_rde();
    pulse_clr();
    chk("t4_tmo_clr", 16'(rx_tmo), 16'h0000);

    // 5: empty read, stray rd_end, double rd_fall
    pulse_rdf();
    chk("t5_empty", xrd_data, EMPTY);
    pulse_rde();
    rx_word(16'h0102);
    rx_word(16'h0304);
    pulse_rde();
    chk("t5_stray_end", 16'(rx_avail), 16'h0001);
    pulse_rdf();
    pulse_rdf();
    chk("t5_same_head", xrd_data, 16'h0102);
    pulse_rde();
    pulse_rdf();
    chk("t5_next", xrd_data, 16'h0304);
    pulse_rde();
    chk("t5_drained", 16'(rx_avail), 16'h0000);

    // RX overflow: ninth word dropped, first eight read back in order
    for (int i = 0; i < 9; i++) rx_word({8'hC0, 8'(i)});
    chk("ovf_rx", 16'(rx_ovf), 16'h0001);
    for (int i = 0; i < 8; i++) begin
      pulse_rdf();
      chk("ovf_drain", xrd_data, {8'hC0, 8'(i)});
      pulse_rde();
    end
    chk("ovf_empty", 16'(rx_avail), 16'h0000);
    pulse_clr();

    // 6: reset during the low-byte start
    rx_word(16'h7777);
    pulse_wr(16'hBEEF);
    found = 0;
    for (int i = 0; i < 200 && found == 0; i++) begin
      tick();
      if (tx_start && tx_data == 8'hEF) found = 1;
    end
    chk("t6_lo_seen", 16'(found), 16'h0001);
    rst_n = 1'b0;
    #1;
    chk("t6_tx_start", 16'(tx_start), 16'h0000);
    chk("t6_flags", 16'({rx_avail, tx_full, tx_ovf, rx_ovf, rx_tmo}), 16'h0000);
    chk("t6_xrd", xrd_data, EMPTY);
    repeat (3) tick();
    rst_n = 1'b1;
    repeat (15) tick();
    seen.delete();
    pulse_wr(16'h0102);
    collect(2, 100, got);
    chk("t6_post_starts", 16'(got), 16'd2);
    chk("t6_post_hi", 16'(seen[0]), 16'h0001);
    chk("t6_post_lo", 16'(seen[1]), 16'h0002);
    repeat (20) tick();

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
